// File: rtl/tbcm_packet_mux.sv
// Packet mux downstream of the matrix arbiter: forwards the granted source's packet to one output stream.
// Optional 2-entry skid output buffer selected by TBCM_PACKET_MUX_SKID_EN (default: single output register).
module tbcm_packet_mux #(
  parameter int SOURCES    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic [SOURCES-1:0]                  o_request,
  input  logic [SOURCES-1:0]                  i_grant,
  output logic [SOURCES-1:0]                  o_free,
  input  logic [SOURCES-1:0]                  i_valid,
  output logic [SOURCES-1:0]                  o_ready,
  input  logic [SOURCES-1:0][DATA_WIDTH-1:0]  i_data,
  input  logic [SOURCES-1:0]                  i_last,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [DATA_WIDTH-1:0]               o_data,
  output logic                                o_last,
  output logic                                o_packet_active
);

  // state | meaning
  // IDLE  | no packet in flight; the arbiter grant selects the source
  // BUSY  | mid-packet; only the latched owner may be accepted
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SOURCES-1:0]     owner_q, owner_d;
  logic [SOURCES-1:0]     sel;
  logic [SOURCES-1:0]     acc_vec;
  logic                   can_accept;
  logic                   accept;
  logic                   in_last;
  logic [DATA_WIDTH-1:0]  in_data;

  always_comb begin
    sel       = (state_q == BUSY) ? (owner_q & i_grant) : i_grant;
    o_request = rst ? '0 : i_valid;
    o_ready   = rst ? '0 : (sel & {SOURCES{can_accept}});
    acc_vec   = i_valid & o_ready;
    accept    = |acc_vec;
    o_free    = acc_vec & i_last;
    in_data   = '0;
    in_last   = 1'b0;
    for (int i = 0; i < SOURCES; i++) begin
      in_data = in_data | (i_data[i] & {DATA_WIDTH{sel[i]}});
      in_last = in_last | (i_last[i] & sel[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = BUSY;
          owner_d = sel;
        end
      end
      BUSY: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign o_packet_active = (state_q == BUSY);

`ifdef TBCM_PACKET_MUX_SKID_EN
  // Ready comes only from the registered count, so i_ready never reaches o_ready.
  logic [1:0]             count_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]  mem_data_q [2];
  logic [1:0]             mem_last_q;
  logic                   drain;

  assign can_accept = (count_q < 2'd2);
  assign drain      = (count_q != 2'd0) && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_last_q    <= 2'b00;
    end else begin
      if (accept) begin
        mem_data_q[wr_ptr_q] <= in_data;
        mem_last_q[wr_ptr_q] <= in_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (drain) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, accept} - {1'b0, drain};
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = mem_data_q[rd_ptr_q];
  assign o_last  = mem_last_q[rd_ptr_q];
`else
  logic                   valid_q;
  logic                   last_q;
  logic [DATA_WIDTH-1:0]  data_q;

  assign can_accept = !valid_q || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      last_q  <= in_last;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
`endif

endmodule

// File: tb/tb_tbcm_packet_mux.sv
// Directed bench for tbcm_packet_mux with a small lock-and-free round-robin arbiter model.
// Skid-buffer checks are compiled in when TBCM_PACKET_MUX_SKID_EN is defined.
`timescale 1ns/1ps
module tb_tbcm_packet_mux;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       o_request, i_grant, o_free, i_valid, o_ready, i_last;
  logic [1:0][31:0] i_data;
  logic             o_valid, i_ready, o_last, o_packet_active;
  logic [31:0]      o_data;

  int n_vec, n_err;
  logic [32:0] outq [$];

  logic       arb_en;
  logic [1:0] man_grant, arb_grant;
  logic       arb_busy, arb_last, arb_pick;

  always #5 clk = ~clk;

  tbcm_packet_mux #(.SOURCES(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .o_request(o_request), .i_grant(i_grant), .o_free(o_free),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_packet_active(o_packet_active)
  );

  // Arbiter model: registered grant, held until free, then one idle cycle before re-arbitration.
  assign i_grant  = arb_en ? arb_grant : man_grant;
  assign arb_pick = o_request[!arb_last] ? !arb_last : arb_last;

  always @(posedge clk) begin
    if (rst || !arb_en) begin
      arb_grant <= 2'b00;
      arb_busy  <= 1'b0;
      arb_last  <= 1'b1;
    end else if (arb_busy) begin
      if (|o_free) begin
        arb_busy  <= 1'b0;
        arb_grant <= 2'b00;
      end
    end else if (|o_request) begin
      arb_grant <= 2'b01 << arb_pick;
      arb_last  <= arb_pick;
      arb_busy  <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (o_valid && i_ready) outq.push_back({o_last, o_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain(input int n);
    i_valid   = 2'b00;
    i_last    = 2'b00;
    man_grant = 2'b00;
    i_ready   = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_out(input string tag, input int base, input int n, input logic [31:0] first);
    chk({tag, "_count"}, 32'(outq.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < outq.size()) begin
        chk({tag, "_data"}, outq[base+k][31:0], first + 32'(k));
        chk({tag, "_last"}, 32'(outq[base+k][32]), 32'(k == n - 1));
      end
    end
  endtask

  initial begin
    int base, idx, cyc, npk, prev_last;
    int pk_owner [$];
    int b [2];
    logic [31:0] pbase [2];
    logic [1:0]  acc;
    n_vec = 0; n_err = 0;
    arb_en = 1'b0; man_grant = 2'b00;
    i_valid = 2'b00; i_last = 2'b00; i_data = '0; i_ready = 1'b1;
    rst = 1'b1;
    step(); step();

    // Reset state, with combinational forcing of request/ready
    i_valid = 2'b01; man_grant = 2'b01; #1;
    chk("rst_request", 32'(o_request), 32'h0);
    chk("rst_ready",   32'(o_ready),   32'h0);
    chk("rst_free",    32'(o_free),    32'h0);
    chk("rst_valid",   32'(o_valid),   32'h0);
    chk("rst_data",    o_data,         32'h0);
    chk("rst_last",    32'(o_last),    32'h0);
    chk("rst_active",  32'(o_packet_active), 32'h0);
    rst = 1'b0; i_valid = 2'b00; man_grant = 2'b00;
    step();

    // Single-beat packet
    base = outq.size();
    i_valid = 2'b01; i_last = 2'b01; i_data[0] = 32'hA5; #1;
    chk("sb_request", 32'(o_request), 32'h1);
    chk("sb_ready_nogrant", 32'(o_ready), 32'h0);
    step();
    man_grant = 2'b01; #1;
    chk("sb_ready", 32'(o_ready), 32'h1);
    chk("sb_free",  32'(o_free),  32'h1);
    step();
    i_valid = 2'b00; man_grant = 2'b00; #1;
    chk("sb_ovalid", 32'(o_valid), 32'h1);
    chk("sb_odata",  o_data,       32'hA5);
    chk("sb_olast",  32'(o_last),  32'h1);
    chk("sb_active", 32'(o_packet_active), 32'h0);
    chk("sb_free_after", 32'(o_free), 32'h0);
    step(); #1;
    chk("sb_drained", 32'(o_valid), 32'h0);
    idle_drain(1);
    chk_out("sb_out", base, 1, 32'hA5);

    // 4-beat packet while source 1 requests; one mismatched-grant stall cycle
    base = outq.size();
    i_data[1] = 32'hBB;
    for (int k = 0; k < 4; k++) begin
      i_valid = 2'b11; i_last = {1'b1, k == 3}; i_data[0] = 32'h10 + 32'(k);
      if (k == 2) begin
        man_grant = 2'b10; #1;
        chk("mc_mismatch_ready", 32'(o_ready), 32'h0);
        chk("mc_mismatch_free",  32'(o_free),  32'h0);
        chk("mc_mismatch_active", 32'(o_packet_active), 32'h1);
        step();
      end
      man_grant = 2'b01; #1;
      chk("mc_ready",  32'(o_ready), 32'h1);
      chk("mc_free",   32'(o_free),  (k == 3) ? 32'h1 : 32'h0);
      chk("mc_active", 32'(o_packet_active), 32'(k != 0));
      step();
    end
    i_valid = 2'b00; man_grant = 2'b00; #1;
    chk("mc_active_end", 32'(o_packet_active), 32'h0);
    idle_drain(3);
    chk_out("mc_out", base, 4, 32'h10);

    // Backpressure mid-packet
    base = outq.size();
    man_grant = 2'b01; i_valid = 2'b01; i_last = 2'b00; i_data[0] = 32'h20; i_ready = 1'b1; #1;
    chk("bp_first_ready", 32'(o_ready), 32'h1);
    step();
    idx = 1;
    for (int j = 0; j < 5; j++) begin
      i_ready = 1'b0; i_data[0] = 32'h20 + 32'(idx); i_last = {1'b0, idx == 3}; #1;
      chk("bp_ovalid", 32'(o_valid), 32'h1);
      chk("bp_odata",  o_data,       32'h20);
`ifdef TBCM_PACKET_MUX_SKID_EN
      chk("bp_ready", 32'(o_ready), 32'(j == 0));
`else
      chk("bp_ready", 32'(o_ready), 32'h0);
`endif
      chk("bp_free", 32'(o_free), 32'h0);
      if (o_ready[0]) idx++;
      step();
    end
    for (int t = 0; t < 20 && idx < 4; t++) begin
      i_ready = 1'b1; i_data[0] = 32'h20 + 32'(idx); i_last = {1'b0, idx == 3}; #1;
      if (o_ready[0]) idx++;
      step();
    end
    chk("bp_beats_accepted", 32'(idx), 32'h4);
    idle_drain(4);
    chk_out("bp_out", base, 4, 32'h20);

    // Round-robin handoff through the arbiter model
    base = outq.size();
    arb_en = 1'b1; i_ready = 1'b1;
    b[0] = 0; b[1] = 0; pbase[0] = 32'h40; pbase[1] = 32'h80;
    npk = 0; prev_last = 0; cyc = 0;
    for (int t = 0; t < 60 && (b[0] < 4 || b[1] < 4); t++) begin
      for (int s = 0; s < 2; s++) begin
        i_valid[s] = (b[s] < 4);
        i_last[s]  = (b[s] % 2) == 1;
        i_data[s]  = pbase[s] + 32'(b[s]);
      end
      #1;
      acc = o_ready & i_valid;
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          if (b[s] % 2 == 0) begin
            if (npk > 0) chk("rr_gap", 32'(cyc - prev_last), 32'h2);
            pk_owner.push_back(s);
            npk++;
          end else begin
            prev_last = cyc;
          end
          b[s]++;
        end
      end
      step();
      cyc++;
    end
    chk("rr_done", 32'(b[0] + b[1]), 32'h8);
    idle_drain(3);
    arb_en = 1'b0;
    chk("rr_npk", 32'(npk), 32'h4);
    for (int p = 0; p < 4; p++)
      if (p < pk_owner.size()) chk("rr_owner", 32'(pk_owner[p]), 32'(p % 2));
    chk("rr_out_count", 32'(outq.size() - base), 32'h8);
    if (outq.size() >= base + 8) begin
      chk("rr_d0", outq[base+0][31:0], 32'h40);
      chk("rr_d1", outq[base+1][31:0], 32'h41);
      chk("rr_d2", outq[base+2][31:0], 32'h80);
      chk("rr_d3", outq[base+3][31:0], 32'h81);
      chk("rr_d4", outq[base+4][31:0], 32'h42);
      chk("rr_d7", outq[base+7][31:0], 32'h83);
      chk("rr_l3", 32'(outq[base+3][32]), 32'h1);
      chk("rr_l4", 32'(outq[base+4][32]), 32'h0);
    end

    // Reset after beat 2 of 4
    man_grant = 2'b01; i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_valid = 2'b01; i_last = 2'b00; i_data[0] = 32'h60 + 32'(k); #1;
      chk("mr_ready", 32'(o_ready), 32'h1);
      step();
    end
    i_data[0] = 32'h62; rst = 1'b1; #1;
    chk("mr_rst_ready",   32'(o_ready),   32'h0);
    chk("mr_rst_free",    32'(o_free),    32'h0);
    chk("mr_rst_request", 32'(o_request), 32'h0);
    step();
    rst = 1'b0; i_valid = 2'b00; man_grant = 2'b00; #1;
    chk("mr_ovalid", 32'(o_valid), 32'h0);
    chk("mr_active", 32'(o_packet_active), 32'h0);
    chk("mr_free",   32'(o_free), 32'h0);
    base = outq.size();
    step();
    man_grant = 2'b10;
    for (int k = 0; k < 2; k++) begin
      i_valid = 2'b10; i_last = {k == 1, 1'b0}; i_data[1] = 32'h70 + 32'(k); #1;
      chk("mr_fresh_ready", 32'(o_ready), 32'h2);
      step();
    end
    idle_drain(3);
    chk_out("mr_out", base, 2, 32'h70);

`ifdef TBCM_PACKET_MUX_SKID_EN
    // Skid buffer with i_ready toggling each cycle
    begin
      int cnt;
      logic tog, r1, r2, a, d;
      base = outq.size(); idx = 0; cnt = 0; tog = 1'b0;
      man_grant = 2'b01;
      for (int t = 0; t < 60 && (idx < 8 || cnt > 0); t++) begin
        i_valid = {1'b0, idx < 8}; i_last = {1'b0, idx == 7}; i_data[0] = 32'h90 + 32'(idx);
        i_ready = tog; #1;
        r1 = o_ready[0];
        i_ready = ~tog; #1;
        r2 = o_ready[0];
        i_ready = tog; #1;
        chk("sk_no_comb_path", 32'(r1), 32'(r2));
        chk("sk_ready", 32'(o_ready[0]), 32'(cnt < 2));
        chk("sk_valid", 32'(o_valid), 32'(cnt > 0));
        a = (cnt < 2) && (idx < 8);
        d = (cnt > 0) && tog;
        cnt = cnt + int'(a) - int'(d);
        if (a) idx++;
        step();
        tog = ~tog;
      end
      chk("sk_beats", 32'(idx), 32'h8);
      idle_drain(3);
      chk_out("sk_out", base, 8, 32'h90);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
